cpu_fetch_seq: RTL and testbench
================================

// Module: cpu_fetch_seq
// PURPOSE
//  Parametrised instruction-fetch sequencer and T-state generator for the 6502-class core.
//  - Runs the reset-vector fetch, then fetches opcode and operand bytes.
//  - Owns the program counter and drives the address bus during fetch.
//  - Steps a variable-length T-state count per instruction, using cycle and byte counts
//    supplied by the decoder.
//  - Replaces the fixed 7-state ring counter and the free-running PC in the core top level.
// PARAMETERS
//  ADDR_W   16       address / PC width
//  DATA_W   8        data bus width, opcode width, operand byte width
//  T_MAX    7        maximum T-states per instruction (>=3); tstate width = $clog2(T_MAX+1)
//  RST_VEC  'hFFFC   address of reset vector low byte; high byte at RST_VEC+1
// PORTS
//  clk        in   1            clock, all state updates on posedge
//  rst        in   1            synchronous reset, active high
//  rdy        in   1            1 = advance; 0 = stall, all state and outputs held
//  d_in       in   DATA_W       read data bus
//  dec_bytes  in   2            instruction length in bytes (1..3), decoded from ir
//  dec_cycles in   3            instruction cycle count (2..T_MAX), decoded from ir
//  ld_pc      in   1            load pc_ld_val into PC at this edge
//  pc_ld_val  in   ADDR_W       jump / branch target
//  is_branch  in   1            qualifies ld_pc as a relative branch (penalty feature only)
//  addr       out  ADDR_W       fetch address
//  pc         out  ADDR_W       program counter
//  ir         out  DATA_W       latched opcode
//  operand    out  2*DATA_W     latched operand, {high, low}
//  tstate     out  clog2        current T-state, 0 = opcode fetch
//  sync       out  1            high during opcode-fetch cycle (T0 of RUN)
//  instr_done out  1            one-cycle pulse in the last T-state of each instruction
// BEHAVIOUR
//  States: RV_LO -> RV_HI -> RUN. RUN is sub-sequenced by tstate.
//  Reset values: state=RV_LO, pc=0, ir=0, operand=0, tstate=0, sync=0, instr_done=0,
//    addr=RST_VEC.
//  Reset mid-operation: rst aborts any instruction; next cycle is RV_LO.
//  RV_LO: addr=RST_VEC; on edge, pc[7:0]<=d_in.
//  RV_HI: addr=RST_VEC+1; on edge, pc[15:8]<=d_in; enter RUN at tstate=0.
//  RUN, T0: sync=1, addr=pc; edge: ir<=d_in, pc<=pc+1, operand<=0.
//  RUN, T1: if eff_bytes>=2, addr=pc; edge: operand[7:0]<=d_in, pc++.
//  RUN, T2: if eff_bytes==3, addr=pc; edge: operand[15:8]<=d_in, pc++.
//  Non-fetch T-states: addr=pc; PC is not incremented.
//  eff_cycles = clamp(dec_cycles, max(2, dec_bytes), T_MAX); eff_bytes = max(1, dec_bytes).
//    Both are sampled from ir every cycle.
//  tstate increments each rdy cycle. At tstate==eff_cycles-1: instr_done=1, next tstate=0.
//  ld_pc beats increment in the same edge; it is legal in any RUN cycle.
//    If ld_pc is in the last T-state, the next T0 fetches from pc_ld_val.
//  rdy=0: no register changes, addr/sync/instr_done held. rdy is ignored while rst=1.
//  PC arithmetic is modulo 2**ADDR_W: 'hFFFF + 1 -> 'h0000, no flag.
//  Fetch latency: opcode is visible on ir one cycle after the sync cycle.
// CONFIGURATION
//  FETCH_SEQ_PAGE_PENALTY_EN defined:
//    ld_pc&is_branch with pc_ld_val[ADDR_W-1:8] != pc[ADDR_W-1:8] inserts one extra T-state
//    before instr_done (eff_cycles+1, may exceed T_MAX by 1).
//  Not defined: is_branch ignored, no extra cycle.
// TESTING
//  1. rst 1 cycle, mem[FFFC]=34, mem[FFFD]=12 -> addr FFFC, FFFD, then sync=1 with addr=1234 at cycle 3.
//  2. 1-byte/2-cycle opcode EA at 1234 -> ir=EA, pc=1235, instr_done at tstate=1, next sync at addr=1235.
//  3. 3-byte/4-cycle opcode at 1235, bytes 78 56 -> operand=5678, pc=1238, instr_done at tstate=3.
//  4. ld_pc=1 with pc_ld_val=2000 in last T-state -> next sync cycle has addr=2000; ld_pc+rdy=0 -> no change.
//  5. pc=FFFF, 1-byte opcode -> pc=0000; dec_cycles=0 -> 2 T-states; dec_cycles=7, T_MAX=5 -> 5 T-states.
//  6. Macro on: branch 10F0->1110 adds 1 T-state; 10F0->1080 adds none. Macro off: no extra. rst at T2 -> RV_LO next.

Source files
------------

// File: rtl/cpu_fetch_seq_if.sv
// Fetch bus between the cpu_fetch_seq sequencer and memory.
// master: the sequencer (drives addr, samples rdy and d_in).
// slave:  the memory side (drives rdy and d_in, samples addr).
interface cpu_fetch_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              rdy;
    logic [DATA_W-1:0] d_in;
    logic [ADDR_W-1:0] addr;

    modport master (input rdy, input d_in, output addr);
    modport slave  (output rdy, output d_in, input addr);
endinterface

// File: rtl/cpu_fetch_seq.sv
// cpu_fetch_seq: instruction-fetch sequencer and T-state generator for the
// 6502-class core. It runs the reset-vector fetch (RV_LO, RV_HI), then
// fetches opcode and operand bytes in RUN. It owns the PC and steps a
// variable-length T-state count that it derives from the decoder's
// byte and cycle counts.
// The PC is assembled from two bus bytes, so ADDR_W is expected to equal 2*DATA_W.
// Optional feature macro: FETCH_SEQ_PAGE_PENALTY_EN. When it is defined, a
// taken branch that crosses a page adds one extra T-state to the instruction.
module cpu_fetch_seq #(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 8,
    parameter int                T_MAX   = 7,
    parameter logic [ADDR_W-1:0] RST_VEC = 16'hFFFC
) (
    input  logic                          clk,
    input  logic                          rst,
    cpu_fetch_seq_if.master               bus,
    input  logic [1:0]                    dec_bytes,
    input  logic [2:0]                    dec_cycles,
    input  logic                          ld_pc,
    input  logic [ADDR_W-1:0]             pc_ld_val,
    input  logic                          is_branch,
    output logic [ADDR_W-1:0]             pc,
    output logic [DATA_W-1:0]             ir,
    output logic [2*DATA_W-1:0]           operand,
    output logic [$clog2(T_MAX+1)-1:0]    tstate,
    output logic                          sync,
    output logic                          instr_done
);
    localparam int TW = $clog2(T_MAX + 1);
    // One bit wider than tstate so that clamp and penalty arithmetic cannot overflow.
    localparam int CW = TW + 1;
    localparam logic [CW-1:0] TMAX_C = CW'(T_MAX);

    typedef enum logic [1:0] {
        ST_RV_LO = 2'd0,
        ST_RV_HI = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_n_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [DATA_W-1:0]   ir_r;
    logic [2*DATA_W-1:0] operand_r;
    logic [TW-1:0]       tstate_r;

    logic [1:0]          eff_bytes_s;
    logic [CW-1:0]       cyc_s;
    logic [CW-1:0]       lo_s;
    logic [CW-1:0]       eff_cycles_s;
    logic [CW-1:0]       last_s;
    logic                fetch_op_s;
    logic                fetch_lo_s;
    logic                fetch_hi_s;
    logic                done_s;
    logic [ADDR_W-1:0]   addr_s;

`ifdef FETCH_SEQ_PAGE_PENALTY_EN
    logic                pen_r;
    logic                pen_hit_s;
`else
    logic                unused_is_branch;
    assign unused_is_branch = is_branch;
`endif

    // The state register advances only on rdy cycles. Reset takes priority over rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RV_LO;
        end else if (bus.rdy) begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic: two vector fetches, then RUN until the next reset.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_RV_LO: state_n_s = ST_RV_HI;
            ST_RV_HI: state_n_s = ST_RUN;
            ST_RUN:   state_n_s = ST_RUN;
            default:  state_n_s = ST_RV_LO;
        endcase
    end

    // Compute effective length and cycle count from the decoder outputs.
    // The cycle count is clamped to [max(2, bytes), T_MAX].
    always_comb begin
        eff_bytes_s = (dec_bytes == 2'd0) ? 2'd1 : dec_bytes;
        cyc_s       = CW'(dec_cycles);
        lo_s        = (dec_bytes == 2'd3) ? CW'(3) : CW'(2);
        if (cyc_s < lo_s) begin
            eff_cycles_s = lo_s;
        end else if (cyc_s > TMAX_C) begin
            eff_cycles_s = TMAX_C;
        end else begin
            eff_cycles_s = cyc_s;
        end
    end

    // Output decode: bus address, fetch strobes, sync and the last-T-state pulse.
    always_comb begin
        fetch_op_s = (state_r == ST_RUN) && (tstate_r == TW'(0));
        fetch_lo_s = (state_r == ST_RUN) && (tstate_r == TW'(1)) && (eff_bytes_s >= 2'd2);
        fetch_hi_s = (state_r == ST_RUN) && (tstate_r == TW'(2)) && (eff_bytes_s == 2'd3);
        case (state_r)
            ST_RV_LO: addr_s = RST_VEC;
            ST_RV_HI: addr_s = RST_VEC + ADDR_W'(1);
            ST_RUN:   addr_s = pc_r;
            default:  addr_s = RST_VEC;
        endcase
`ifdef FETCH_SEQ_PAGE_PENALTY_EN
        pen_hit_s = (state_r == ST_RUN) && ld_pc && is_branch &&
                    (pc_ld_val[ADDR_W-1:DATA_W] != pc_r[ADDR_W-1:DATA_W]);
        last_s    = eff_cycles_s - CW'(1) + CW'(pen_r);
        // A page-crossing branch in the nominal last T-state defers completion by one.
        done_s    = (state_r == ST_RUN) && ({1'b0, tstate_r} == last_s) && !(pen_hit_s && !pen_r);
`else
        last_s    = eff_cycles_s - CW'(1);
        done_s    = (state_r == ST_RUN) && ({1'b0, tstate_r} == last_s);
`endif
    end

    // Datapath registers: PC, opcode, operand and T-state counter; held when rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= '0;
            ir_r      <= '0;
            operand_r <= '0;
            tstate_r  <= '0;
`ifdef FETCH_SEQ_PAGE_PENALTY_EN
            pen_r     <= 1'b0;
`endif
        end else if (bus.rdy) begin
            case (state_r)
                ST_RV_LO: pc_r[DATA_W-1:0] <= bus.d_in;
                ST_RV_HI: begin
                    pc_r[ADDR_W-1:DATA_W] <= bus.d_in;
                    tstate_r              <= '0;
                end
                ST_RUN: begin
                    if (fetch_op_s) begin
                        ir_r      <= bus.d_in;
                        operand_r <= '0;
                    end
                    if (fetch_lo_s) begin
                        operand_r[DATA_W-1:0] <= bus.d_in;
                    end
                    if (fetch_hi_s) begin
                        operand_r[2*DATA_W-1:DATA_W] <= bus.d_in;
                    end
                    // A jump target overrides the fetch increment in the same cycle.
                    if (ld_pc) begin
                        pc_r <= pc_ld_val;
                    end else if (fetch_op_s || fetch_lo_s || fetch_hi_s) begin
                        pc_r <= pc_r + ADDR_W'(1);
                    end
                    tstate_r <= done_s ? TW'(0) : tstate_r + TW'(1);
`ifdef FETCH_SEQ_PAGE_PENALTY_EN
                    pen_r <= done_s ? 1'b0 : (pen_r | pen_hit_s);
`endif
                end
                default: tstate_r <= '0;
            endcase
        end
    end

    assign bus.addr   = addr_s;
    assign pc         = pc_r;
    assign ir         = ir_r;
    assign operand    = operand_r;
    assign tstate     = tstate_r;
    assign sync       = fetch_op_s;
    assign instr_done = done_s;
endmodule

// File: tb/tb_cpu_fetch_seq.sv
// Directed self-checking bench for cpu_fetch_seq. The bench acts as both the
// memory model and the opcode decoder. A second instance with T_MAX=5 checks
// the upper clamp of the cycle count.
module tb_cpu_fetch_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        rst2;
    logic        ld_pc;
    logic        is_branch;
    logic [15:0] pc_ld_val;
    logic [7:0]  mem [0:65535];

    logic [1:0]  dec_bytes,  dec_bytes2;
    logic [2:0]  dec_cycles, dec_cycles2;
    logic [15:0] pc, pc2;
    logic [7:0]  ir, ir2;
    logic [15:0] operand, operand2;
    logic [2:0]  tstate, tstate2;
    logic        sync, sync2, instr_done, instr_done2;

    int n_total = 0;
    int n_pass  = 0;

    cpu_fetch_seq_if #(.ADDR_W(16), .DATA_W(8)) bus  ();
    cpu_fetch_seq_if #(.ADDR_W(16), .DATA_W(8)) bus2 ();

    always #5 clk = ~clk;

    assign bus.d_in  = mem[bus.addr];
    assign bus2.d_in = mem[bus2.addr];
    assign bus2.rdy  = bus.rdy;

    // Opcode table: {bytes[1:0], cycles[2:0]}.
    function automatic logic [4:0] decode(input logic [7:0] op);
        case (op)
            8'hEA:   decode = {2'd1, 3'd2};
            8'hAD:   decode = {2'd3, 3'd4};
            8'hA9:   decode = {2'd2, 3'd2};
            8'hF0:   decode = {2'd2, 3'd2};
            8'h00:   decode = {2'd1, 3'd0};
            8'hBB:   decode = {2'd1, 3'd7};
            default: decode = {2'd1, 3'd2};
        endcase
    endfunction

    always_comb {dec_bytes,  dec_cycles}  = decode(ir);
    always_comb {dec_bytes2, dec_cycles2} = decode(ir2);

    cpu_fetch_seq #(.ADDR_W(16), .DATA_W(8), .T_MAX(7), .RST_VEC(16'hFFFC)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .dec_bytes(dec_bytes), .dec_cycles(dec_cycles),
        .ld_pc(ld_pc), .pc_ld_val(pc_ld_val), .is_branch(is_branch),
        .pc(pc), .ir(ir), .operand(operand), .tstate(tstate),
        .sync(sync), .instr_done(instr_done)
    );

    cpu_fetch_seq #(.ADDR_W(16), .DATA_W(8), .T_MAX(5), .RST_VEC(16'hFFFC)) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2),
        .dec_bytes(dec_bytes2), .dec_cycles(dec_cycles2),
        .ld_pc(ld_pc), .pc_ld_val(pc_ld_val), .is_branch(is_branch),
        .pc(pc2), .ir(ir2), .operand(operand2), .tstate(tstate2),
        .sync(sync2), .instr_done(instr_done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
        mem[16'h1234] = 8'hEA;
        mem[16'h1235] = 8'hAD; mem[16'h1236] = 8'h78; mem[16'h1237] = 8'h56;
        mem[16'h2000] = 8'hA9; mem[16'h2001] = 8'h05;
        mem[16'hFFFF] = 8'h00;
        mem[16'h0000] = 8'hBB;
        mem[16'h0001] = 8'hEA;
        mem[16'h10F0] = 8'hF0; mem[16'h10F1] = 8'h20;
        mem[16'h1110] = 8'hEA;
        mem[16'h1080] = 8'hAD;

        rst = 1'b1; rst2 = 1'b1; bus.rdy = 1'b1;
        ld_pc = 1'b0; is_branch = 1'b0; pc_ld_val = 16'h0000;

        // Reset state
        step;
        chk("rst_addr", 32'(bus.addr), 32'hFFFC);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_operand", 32'(operand), 32'h0);
        chk("rst_tstate", 32'(tstate), 32'h0);
        chk("rst_sync", 32'(sync), 32'h0);
        chk("rst_done", 32'(instr_done), 32'h0);

        // Reset vector fetch
        rst = 1'b0;
        step;
        chk("rv_hi_addr", 32'(bus.addr), 32'hFFFD);
        step;
        chk("t0_sync", 32'(sync), 32'h1);
        chk("t0_addr", 32'(bus.addr), 32'h1234);

        // 1-byte / 2-cycle opcode
        step;
        chk("nop_ir", 32'(ir), 32'hEA);
        chk("nop_pc", 32'(pc), 32'h1235);
        chk("nop_t1_done", 32'({tstate, instr_done}), 32'({3'd1, 1'b1}));
        chk("nop_t1_sync", 32'(sync), 32'h0);
        step;
        chk("nop_next_sync", 32'({sync, bus.addr}), 32'({1'b1, 16'h1235}));

        // 3-byte / 4-cycle opcode
        step;
        chk("abs_t1_addr", 32'(bus.addr), 32'h1236);
        chk("abs_t1_done", 32'(instr_done), 32'h0);
        step;
        chk("abs_t2_op", 32'(operand), 32'h0078);
        step;
        chk("abs_operand", 32'(operand), 32'h5678);
        chk("abs_pc", 32'(pc), 32'h1238);
        chk("abs_t3_done", 32'({tstate, instr_done}), 32'({3'd3, 1'b1}));

        // ld_pc in last T-state, first with a stall
        ld_pc = 1'b1; pc_ld_val = 16'h2000; bus.rdy = 1'b0;
        step;
        chk("stall_pc", 32'(pc), 32'h1238);
        chk("stall_t", 32'({tstate, instr_done, bus.addr}), 32'({3'd3, 1'b1, 16'h1238}));
        bus.rdy = 1'b1;
        step;
        ld_pc = 1'b0;
        chk("jmp_sync", 32'({sync, bus.addr}), 32'({1'b1, 16'h2000}));
        chk("jmp_pc", 32'(pc), 32'h2000);

        // 2-byte opcode, then jump to FFFF while the operand is latched
        step;
        chk("imm_t1", 32'({tstate, instr_done, bus.addr}), 32'({3'd1, 1'b1, 16'h2001}));
        ld_pc = 1'b1; pc_ld_val = 16'hFFFF;
        step;
        ld_pc = 1'b0;
        chk("imm_operand", 32'(operand), 32'h0005);
        chk("ffff_sync", 32'({sync, bus.addr}), 32'({1'b1, 16'hFFFF}));

        // PC wrap and dec_cycles=0 clamp to two T-states
        step;
        chk("wrap_pc", 32'(pc), 32'h0000);
        chk("clamp_lo", 32'({tstate, instr_done}), 32'({3'd1, 1'b1}));
        step;
        chk("wrap_sync", 32'({sync, bus.addr}), 32'({1'b1, 16'h0000}));

        // 7-cycle opcode, T_MAX=7
        step;
        chk("bb_t1_done", 32'(instr_done), 32'h0);
        repeat (5) step;
        chk("bb_t6", 32'({tstate, instr_done}), 32'({3'd6, 1'b1}));
        chk("bb_pc", 32'(pc), 32'h0001);
        step;
        chk("bb_next_sync", 32'({sync, bus.addr}), 32'({1'b1, 16'h0001}));

        // Jump to 10F0, then a page-crossing branch to 1110
        step;
        ld_pc = 1'b1; pc_ld_val = 16'h10F0;
        step;
        ld_pc = 1'b0;
        chk("br_sync", 32'({sync, bus.addr}), 32'({1'b1, 16'h10F0}));
        step;
        ld_pc = 1'b1; is_branch = 1'b1; pc_ld_val = 16'h1110;
        #1;
`ifdef FETCH_SEQ_PAGE_PENALTY_EN
        chk("br_cross_t1", 32'(instr_done), 32'h0);
        step;
        ld_pc = 1'b0; is_branch = 1'b0;
        chk("br_cross_t2", 32'({tstate, instr_done, pc}), 32'({3'd2, 1'b1, 16'h1110}));
        step;
`else
        chk("br_cross_t1", 32'(instr_done), 32'h1);
        step;
        ld_pc = 1'b0; is_branch = 1'b0;
`endif
        chk("br_cross_tgt", 32'({sync, bus.addr, tstate}), 32'({1'b1, 16'h1110, 3'd0}));
        chk("br_operand", 32'(operand), 32'h0020);

        // Same-page branch 10F0 -> 1080
        step;
        ld_pc = 1'b1; pc_ld_val = 16'h10F0;
        step;
        ld_pc = 1'b0;
        step;
        ld_pc = 1'b1; is_branch = 1'b1; pc_ld_val = 16'h1080;
        #1;
        chk("br_same_done", 32'({tstate, instr_done}), 32'({3'd1, 1'b1}));
        step;
        ld_pc = 1'b0; is_branch = 1'b0;
        chk("br_same_tgt", 32'({sync, bus.addr, tstate}), 32'({1'b1, 16'h1080, 3'd0}));

        // Reset at T2 of a 3-byte opcode, with rdy low
        step;
        step;
        chk("mid_t2", 32'(tstate), 32'h2);
        rst = 1'b1; bus.rdy = 1'b0;
        step;
        chk("mid_rst_addr", 32'({bus.addr, sync, tstate}), 32'({16'hFFFC, 1'b0, 3'd0}));
        chk("mid_rst_regs", 32'({pc, ir}), 32'h0);
        rst = 1'b0; bus.rdy = 1'b1;

        // T_MAX=5 instance: 7-cycle opcode clamps to 5 T-states
        mem[16'h1234] = 8'hBB;
        step;
        rst2 = 1'b0;
        step;
        step;
        chk("tmax_sync", 32'({sync2, bus2.addr}), 32'({1'b1, 16'h1234}));
        step;
        chk("tmax_t1", 32'({tstate2, instr_done2}), 32'({3'd1, 1'b0}));
        repeat (3) step;
        chk("tmax_t4", 32'({tstate2, instr_done2}), 32'({3'd4, 1'b1}));
        step;
        chk("tmax_next", 32'({sync2, bus2.addr}), 32'({1'b1, 16'h1235}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
